// File: rtl/segway_pkg.sv
// Shared constants and helpers for the segway math pipeline.
package segway_pkg;

    localparam int MIN_DUTY        = 'h0A8;
    localparam int LOW_TORQUE_BAND = 42;
    localparam int GAIN_MULT       = 4;
    localparam int STEER_MIN       = 'h200;
    localparam int STEER_MAX       = 'hE00;
    localparam int FAST_THR        = 1536;
    localparam int SLEW_STEP       = 16;

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic int saturate(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/segway_math_pipe_torque_shaper.sv
// Dead-zone / low-torque gain shaping for one motor side; output is zero when disabled.
module torque_shaper
    import segway_pkg::*;
#(
    parameter int W               = 13,
    parameter int MIN_DUTY        = segway_pkg::MIN_DUTY,
    parameter int LOW_TORQUE_BAND = segway_pkg::LOW_TORQUE_BAND,
    parameter int GAIN_MULT       = segway_pkg::GAIN_MULT
) (
    input  logic signed [W-1:0] t_i,
    input  logic                en_i,
    output logic signed [W-1:0] t_o
);

    localparam logic signed [W-1:0] MIN_C  = W'(MIN_DUTY);
    localparam logic        [W-1:0] BAND_C = W'(LOW_TORQUE_BAND);
    localparam logic signed [W-1:0] GAIN_C = W'(GAIN_MULT);

    logic [W-1:0] mag;

    always_comb begin
        mag = t_i[W-1] ? -t_i : t_i;
        t_o = '0;
        if (en_i) begin
            if (mag > BAND_C) begin
                t_o = t_i[W-1] ? (t_i - MIN_C) : (t_i + MIN_C);
            end else begin
                t_o = t_i * GAIN_C;
            end
        end
    end

endmodule

// File: rtl/segway_math_pipe.sv
// Balance-control math pipeline: soft-start, steering mix, shaping, saturation.
// Define SEGWAY_SLEW_LIMIT_EN to add an output slew-limit stage (one extra cycle of latency).
module segway_math_pipe
    import segway_pkg::*;
#(
    parameter int SPD_W           = 12,
    parameter int SS_W            = 8,
    parameter int MIN_DUTY        = segway_pkg::MIN_DUTY,
    parameter int LOW_TORQUE_BAND = segway_pkg::LOW_TORQUE_BAND,
    parameter int GAIN_MULT       = segway_pkg::GAIN_MULT,
    parameter int STEER_MIN       = segway_pkg::STEER_MIN,
    parameter int STEER_MAX       = segway_pkg::STEER_MAX,
`ifdef SEGWAY_SLEW_LIMIT_EN
    parameter int SLEW_STEP       = segway_pkg::SLEW_STEP,
`endif
    parameter int FAST_THR        = segway_pkg::FAST_THR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld,
    input  logic signed [SPD_W-1:0] PID_cntrl,
    input  logic        [SPD_W-1:0] steer_pot,
    input  logic                    en_steer,
    input  logic                    pwr_up,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    too_fast,
    output logic                    spd_vld
);

    localparam int PROD_W = SPD_W + SS_W + 1;
    localparam int TW     = SPD_W + 1;

    localparam logic        [SPD_W-1:0] STEER_MIN_C = SPD_W'(STEER_MIN);
    localparam logic        [SPD_W-1:0] STEER_MAX_C = SPD_W'(STEER_MAX);
    localparam logic signed [TW-1:0]    CENTER_C    = TW'((1 << (SPD_W - 1)) - 1);
    localparam logic signed [SPD_W-1:0] FAST_C      = SPD_W'(FAST_THR);

    // Soft-start counter
    logic [SS_W-1:0] ss_q, ss_d;

    always_comb begin
        ss_d = ss_q;
        if (!pwr_up) begin
            ss_d = '0;
        end else if (vld && (ss_q != '1)) begin
            ss_d = ss_q + 1'b1;
        end
    end

    // S1: soft-start scale and steering ratio
    logic signed [PROD_W-1:0] pid_x, ss_x, prod;
    logic signed [SPD_W-1:0]  pid_ss_d, pid_ss_q;
    logic        [SPD_W-1:0]  steer_clip;
    logic signed [TW-1:0]     cen, ratio_d, ratio_q;
    logic                     pwr1_q, en1_q, v1_q;

    always_comb begin
        pid_x    = PROD_W'(PID_cntrl);
        ss_x     = $signed(PROD_W'({1'b0, ss_q}));
        prod     = pid_x * ss_x;
        pid_ss_d = SPD_W'(prod >>> SS_W);
        if (steer_pot < STEER_MIN_C) begin
            steer_clip = STEER_MIN_C;
        end else if (steer_pot > STEER_MAX_C) begin
            steer_clip = STEER_MAX_C;
        end else begin
            steer_clip = steer_pot;
        end
        cen     = $signed({1'b0, steer_clip}) - CENTER_C;
        ratio_d = (cen >>> 3) + (cen >>> 4);
    end

    // S2: steering mix and per-side shaping
    logic signed [TW-1:0] p_ext, lft_t, rght_t, lft_sh, rght_sh, lft2_q, rght2_q;
    logic                 v2_q;

    always_comb begin
        p_ext  = TW'(pid_ss_q);
        lft_t  = en1_q ? (p_ext + ratio_q) : p_ext;
        rght_t = en1_q ? (p_ext - ratio_q) : p_ext;
    end

    torque_shaper #(
        .W              (TW),
        .MIN_DUTY       (MIN_DUTY),
        .LOW_TORQUE_BAND(LOW_TORQUE_BAND),
        .GAIN_MULT      (GAIN_MULT)
    ) u_shape_lft (
        .t_i (lft_t),
        .en_i(pwr1_q),
        .t_o (lft_sh)
    );

    torque_shaper #(
        .W              (TW),
        .MIN_DUTY       (MIN_DUTY),
        .LOW_TORQUE_BAND(LOW_TORQUE_BAND),
        .GAIN_MULT      (GAIN_MULT)
    ) u_shape_rght (
        .t_i (rght_t),
        .en_i(pwr1_q),
        .t_o (rght_sh)
    );

    // S3: saturation and over-speed detection
    logic signed [SPD_W-1:0] lft_sat, rght_sat;
    logic                    tf_d;

    always_comb begin
        lft_sat  = SPD_W'(saturate(int'(lft2_q), SPD_W));
        rght_sat = SPD_W'(saturate(int'(rght2_q), SPD_W));
        tf_d     = (lft_sat > FAST_C) | (rght_sat > FAST_C);
    end

    logic signed [SPD_W-1:0] lft_q, rght_q;
    logic                    tf_q, vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q     <= '0;
            pid_ss_q <= '0;
            ratio_q  <= '0;
            pwr1_q   <= 1'b0;
            en1_q    <= 1'b0;
            v1_q     <= 1'b0;
            lft2_q   <= '0;
            rght2_q  <= '0;
            v2_q     <= 1'b0;
        end else begin
            ss_q <= ss_d;
            v1_q <= vld;
            v2_q <= v1_q;
            if (vld) begin
                pid_ss_q <= pid_ss_d;
                ratio_q  <= ratio_d;
                pwr1_q   <= pwr_up;
                en1_q    <= en_steer;
            end
            if (v1_q) begin
                lft2_q  <= lft_sh;
                rght2_q <= rght_sh;
            end
        end
    end

`ifdef SEGWAY_SLEW_LIMIT_EN
    localparam logic signed [TW-1:0] STEP_C = TW'(SLEW_STEP);

    logic signed [SPD_W-1:0] lft3_q, rght3_q;
    logic                    tf3_q, pwr2_q, pwr3_q, v3_q;

    function automatic logic signed [SPD_W-1:0] slew_next(input logic signed [SPD_W-1:0] tgt,
                                                          input logic signed [SPD_W-1:0] prev);
        logic signed [TW-1:0] diff;
        diff = TW'(tgt) - TW'(prev);
        if (diff > STEP_C) begin
            diff = STEP_C;
        end else if (diff < -STEP_C) begin
            diff = -STEP_C;
        end
        return SPD_W'(TW'(prev) + diff);
    endfunction

    // S4: a powered-down sample snaps to zero rather than ramping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwr2_q  <= 1'b0;
            pwr3_q  <= 1'b0;
            lft3_q  <= '0;
            rght3_q <= '0;
            tf3_q   <= 1'b0;
            v3_q    <= 1'b0;
            lft_q   <= '0;
            rght_q  <= '0;
            tf_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            v3_q  <= v2_q;
            vld_q <= v3_q;
            if (v1_q) begin
                pwr2_q <= pwr1_q;
            end
            if (v2_q) begin
                lft3_q  <= lft_sat;
                rght3_q <= rght_sat;
                tf3_q   <= tf_d;
                pwr3_q  <= pwr2_q;
            end
            if (v3_q) begin
                lft_q  <= pwr3_q ? slew_next(lft3_q, lft_q) : '0;
                rght_q <= pwr3_q ? slew_next(rght3_q, rght_q) : '0;
                tf_q   <= tf3_q;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_q  <= '0;
            rght_q <= '0;
            tf_q   <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= v2_q;
            if (v2_q) begin
                lft_q  <= lft_sat;
                rght_q <= rght_sat;
                tf_q   <= tf_d;
            end
        end
    end
`endif

    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign too_fast = tf_q;
    assign spd_vld  = vld_q;

endmodule

// File: tb/tb_segway_math_pipe.sv
// Directed-vector bench for segway_math_pipe (default build and SEGWAY_SLEW_LIMIT_EN build).
module tb_segway_math_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [11:0] pid;
    logic [11:0] steer;
    logic        en_steer;
    logic        pwr_up;
    logic [11:0] lft;
    logic [11:0] rght;
    logic        tf;
    logic        sv;

    always #5 clk = ~clk;

`ifdef SEGWAY_SLEW_LIMIT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    segway_math_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .vld      (vld),
        .PID_cntrl(pid),
        .steer_pot(steer),
        .en_steer (en_steer),
        .pwr_up   (pwr_up),
        .lft_spd  (lft),
        .rght_spd (rght),
        .too_fast (tf),
        .spd_vld  (sv)
    );

    int n_vec  = 0;
    int n_miss = 0;
    logic [24:0] exp_q[$];

    typedef struct {
        logic [11:0] pid;
        logic [11:0] steer;
        logic        en;
        logic        pwr;
        logic [11:0] lft;
        logic [11:0] rght;
        logic        tf;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one sample and return the outputs of its strobe; latency is checked too.
    task automatic send(input logic [11:0] p, input logic [11:0] s, input logic en, input logic pw,
                        output logic [11:0] l, output logic [11:0] r, output logic t);
        int  n;
        bit  seen;
        @(negedge clk);
        pid = p; steer = s; en_steer = en; pwr_up = pw; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        seen = 1'b0;
        l = '0; r = '0; t = 1'b0;
        for (n = 0; n < 8; n++) begin
            if (sv) begin
                seen = 1'b1;
                l = lft; r = rght; t = tf;
                break;
            end
            @(negedge clk);
        end
        check("latency", seen ? n : 99, LAT);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] l, r;
        logic        t;
        int          ss, p, e;
        logic [11:0] bp[5];
        logic [24:0] be[5];

        vt[0]  = '{12'h7FF, 12'h800, 1'b0, 1'b1, 12'h7FF, 12'h7FF, 1'b1};
        vt[1]  = '{12'h800, 12'h800, 1'b0, 1'b1, 12'h800, 12'h800, 1'b0};
        vt[2]  = '{12'h00A, 12'h800, 1'b0, 1'b1, 12'h024, 12'h024, 1'b0};
        vt[3]  = '{12'hFF6, 12'h800, 1'b0, 1'b1, 12'hFD8, 12'hFD8, 1'b0};
        vt[4]  = '{12'h02B, 12'h800, 1'b0, 1'b1, 12'h0A8, 12'h0A8, 1'b0};
        vt[5]  = '{12'h02C, 12'h800, 1'b0, 1'b1, 12'h0D3, 12'h0D3, 1'b0};
        vt[6]  = '{12'h55E, 12'h800, 1'b0, 1'b1, 12'h600, 12'h600, 1'b0};
        vt[7]  = '{12'h55F, 12'h800, 1'b0, 1'b1, 12'h601, 12'h601, 1'b1};
        vt[8]  = '{12'h000, 12'hFFF, 1'b1, 1'b1, 12'h1C8, 12'hE38, 1'b0};
        vt[9]  = '{12'h000, 12'hFFF, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0};
        vt[10] = '{12'h000, 12'h000, 1'b1, 1'b1, 12'hE38, 12'h1C8, 1'b0};
        vt[11] = '{12'h000, 12'h7FF, 1'b1, 1'b1, 12'h000, 12'h000, 1'b0};
        vt[12] = '{12'h000, 12'h800, 1'b1, 1'b1, 12'h000, 12'h000, 1'b0};
        vt[13] = '{12'h400, 12'hFFF, 1'b1, 1'b1, 12'h5C4, 12'h384, 1'b0};

        bp[0] = 12'h00A; be[0] = {1'b0, 12'h024, 12'h024};
        bp[1] = 12'h02B; be[1] = {1'b0, 12'h0A8, 12'h0A8};
        bp[2] = 12'h02C; be[2] = {1'b0, 12'h0D3, 12'h0D3};
        bp[3] = 12'h7FF; be[3] = {1'b1, 12'h7FF, 12'h7FF};
        bp[4] = 12'h800; be[4] = {1'b0, 12'h800, 12'h800};

        // clock/reset
        rst = 1'b1; vld = 1'b0; pid = '0; steer = '0; en_steer = 1'b0; pwr_up = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_lft", lft, 0);
        check("reset_rght", rght, 0);
        check("reset_tf", tf, 0);
        check("reset_vld", sv, 0);
        rst = 1'b0;

`ifdef SEGWAY_SLEW_LIMIT_EN
        for (int k = 0; k < 256; k++) begin
            send(12'h000, 12'h800, 1'b0, 1'b1, l, r, t);
            if (k == 255) check("slew_zero", l, 0);
        end
        for (int k = 0; k < 80; k++) begin
            send(12'h400, 12'h800, 1'b0, 1'b1, l, r, t);
            e = (16 * (k + 1) > 'h4A4) ? 'h4A4 : 16 * (k + 1);
            check("slew_lft", l, e);
            check("slew_rght", r, e);
        end
        send(12'h400, 12'h800, 1'b0, 1'b0, l, r, t);
        check("slew_pwr_drop_lft", l, 0);
        check("slew_pwr_drop_rght", r, 0);
`else
        // Soft start: pwr_up rises together with the first vld.
        for (int k = 0; k < 300; k++) begin
            send(12'h400, 12'h800, 1'b0, 1'b1, l, r, t);
            ss = (k > 255) ? 255 : k;
            p  = 4 * ss;
            e  = (p <= 42) ? 4 * p : p + 168;
            check("softstart_lft", l, e);
            check("softstart_rght", r, e);
            check("softstart_tf", t, 0);
        end

        for (int i = 0; i < 14; i++) begin
            send(vt[i].pid, vt[i].steer, vt[i].en, vt[i].pwr, l, r, t);
            check($sformatf("vec%0d_lft", i), l, vt[i].lft);
            check($sformatf("vec%0d_rght", i), r, vt[i].rght);
            check($sformatf("vec%0d_tf", i), t, vt[i].tf);
        end

        // Back-to-back burst; pwr_up drops while the samples are still in flight.
        @(negedge clk);
        pid = bp[0]; steer = 12'h800; en_steer = 1'b0; pwr_up = 1'b1; vld = 1'b1;
        exp_q.push_back(be[0]);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("burst_vld", sv, (k >= 3 && k <= 7));
            if (sv && exp_q.size() > 0) check("burst_data", {tf, lft, rght}, exp_q.pop_front());
            if (k < 5) begin
                pid = bp[k];
                exp_q.push_back(be[k]);
            end else begin
                vld = 1'b0;
                pwr_up = 1'b0;
            end
        end
        check("burst_drain", exp_q.size(), 0);

        // Power cycle: powered-down sample is zero, first powered sample uses ss_tmr = 0.
        send(12'h400, 12'h800, 1'b0, 1'b0, l, r, t);
        check("pwr_off_lft", l, 0);
        check("pwr_off_rght", r, 0);
        send(12'h400, 12'h800, 1'b0, 1'b1, l, r, t);
        check("pwr_first_lft", l, 0);
        send(12'h400, 12'h800, 1'b0, 1'b1, l, r, t);
        check("pwr_second_lft", l, 12'h010);
        check("pwr_second_rght", r, 12'h010);

        // Asynchronous reset in the middle of a burst.
        @(negedge clk);
        pid = 12'h7FF; steer = 12'h800; en_steer = 1'b0; pwr_up = 1'b1; vld = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pre_vld", sv, 1);
        check("rst_pre_lft", lft, 12'h03C);
        #2 rst = 1'b1;
        #1;
        check("rst_async_vld", sv, 0);
        check("rst_async_lft", lft, 0);
        check("rst_async_rght", rght, 0);
        check("rst_async_tf", tf, 0);
        @(negedge clk);
        vld = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rst_stale_vld", sv, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
